tw_cmd_sequencer: RTL and testbench

Command front-end for the three-wire serial master. It accepts register read/write commands from the host-side bus through a valid/ready interface and buffers them in a small FIFO. It issues them one at a time to the serial engine's start/busy interface and returns one response per command, carrying read data and status. It sits directly upstream of the three-wire engine and owns its `r_w`, `addr`, `wr_data` and `start` inputs.

---
 rtl/tw_pkg.sv | 17 +
 rtl/tw_cmd_sequencer_if.sv | 33 +++
 rtl/tw_cmd_fifo.sv | 56 +++++
 rtl/tw_cmd_sequencer.sv | 178 +++++++++++++++++
 tb/tb_tw_cmd_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tw_pkg.sv
// Definitions shared by the three-wire command sequencer and the serial engine.
package tw_pkg;

    localparam int unsigned TW_ADDR_BITS = 9;
    localparam int unsigned TW_DATA_BITS = 16;

    localparam logic TW_READ  = 1'b0;
    localparam logic TW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        RESPOND   = 2'd3
    } tw_seq_state_e;

endpackage

// File: rtl/tw_cmd_sequencer_if.sv
// Host-side command/response channels of the three-wire sequencer.
interface tw_cmd_sequencer_if
    import tw_pkg::*;
#(
    parameter int unsigned ADDR_BITS = TW_ADDR_BITS,
    parameter int unsigned DATA_BITS = TW_DATA_BITS
);

    logic                 in_cmd_valid;
    logic                 out_cmd_ready;
    logic                 in_cmd_r_w;
    logic [ADDR_BITS-1:0] in_cmd_addr;
    logic [DATA_BITS-1:0] in_cmd_wr_data;

    logic                 out_rsp_valid;
    logic                 in_rsp_ready;
    logic [DATA_BITS-1:0] out_rsp_data;
    logic [ADDR_BITS-1:0] out_rsp_addr;
    logic                 out_rsp_err;

    // Host side: issues commands, consumes responses.
    modport master (
        output in_cmd_valid, in_cmd_r_w, in_cmd_addr, in_cmd_wr_data, in_rsp_ready,
        input  out_cmd_ready, out_rsp_valid, out_rsp_data, out_rsp_addr, out_rsp_err
    );

    // Sequencer side.
    modport slave (
        input  in_cmd_valid, in_cmd_r_w, in_cmd_addr, in_cmd_wr_data, in_rsp_ready,
        output out_cmd_ready, out_rsp_valid, out_rsp_data, out_rsp_addr, out_rsp_err
    );

endinterface

// File: rtl/tw_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit to separate full from empty.
module tw_cmd_fifo #(
    parameter int unsigned WIDTH = 26,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   in_clk,
    input  logic                   in_rst,
    input  logic                   in_push,
    input  logic [WIDTH-1:0]       in_push_data,
    input  logic                   in_pop,
    output logic [WIDTH-1:0]       out_pop_data,
    output logic                   out_full,
    output logic                   out_empty,
    output logic [$clog2(DEPTH):0] out_level
);

    localparam int unsigned IDX_BITS = $clog2(DEPTH);

    logic [IDX_BITS:0]   wr_ptr_q, rd_ptr_q, level_q;
    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic                push_en, pop_en;
    logic [IDX_BITS-1:0] wr_idx, rd_idx;

    assign wr_idx    = wr_ptr_q[IDX_BITS-1:0];
    assign rd_idx    = rd_ptr_q[IDX_BITS-1:0];
    assign out_full  = (wr_ptr_q[IDX_BITS] != rd_ptr_q[IDX_BITS]) && (wr_idx == rd_idx);
    assign out_empty = (wr_ptr_q == rd_ptr_q);

    // A pop frees the head slot in the same cycle, so a full FIFO may take a push alongside it.
    assign push_en = in_push && (!out_full || in_pop);
    assign pop_en  = in_pop && !out_empty;

    assign out_pop_data = mem_q[rd_idx];
    assign out_level    = level_q;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_en, pop_en})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge in_clk) begin
        if (push_en) mem_q[wr_idx] <= in_push_data;
    end

endmodule

// File: rtl/tw_cmd_sequencer.sv
// Buffers host commands and runs them one at a time on the three-wire serial engine.
// Optional per-phase handshake timeout: define TW_SEQ_TIMEOUT_EN.
module tw_cmd_sequencer
    import tw_pkg::*;
#(
    parameter int unsigned ADDR_BITS      = TW_ADDR_BITS,
    parameter int unsigned DATA_BITS      = TW_DATA_BITS,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                        in_clk,
    input  logic                        in_rst,
    tw_cmd_sequencer_if.slave           bus,
    output logic                        out_tw_r_w,
    output logic [ADDR_BITS-1:0]        out_tw_addr,
    output logic [DATA_BITS-1:0]        out_tw_wr_data,
    output logic                        out_tw_start,
    input  logic                        in_tw_busy,
    input  logic [DATA_BITS-1:0]        in_tw_rd_data,
    output logic [$clog2(FIFO_DEPTH):0] out_fifo_level
);

    localparam int unsigned CMD_BITS = 1 + ADDR_BITS + DATA_BITS;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES == 0)
    begin : g_bad_param
        $error("tw_cmd_sequencer: FIFO_DEPTH must be a power of two >= 2, TIMEOUT_CYCLES > 0");
    end

    tw_seq_state_e state_q, state_d;

    logic                 tw_r_w_q, tw_r_w_d;
    logic [ADDR_BITS-1:0] tw_addr_q, tw_addr_d;
    logic [DATA_BITS-1:0] tw_wr_data_q, tw_wr_data_d;
    logic                 tw_start_q, tw_start_d;

    logic                 rsp_valid_q, rsp_valid_d;
    logic [DATA_BITS-1:0] rsp_data_q, rsp_data_d;
    logic [ADDR_BITS-1:0] rsp_addr_q, rsp_addr_d;
    logic                 rsp_err_q, rsp_err_d;

    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CMD_BITS-1:0]  fifo_rd_data;
    logic                 tmo_expired;

    assign bus.out_cmd_ready = !fifo_full;
    assign fifo_push         = bus.in_cmd_valid && !fifo_full;

    tw_cmd_fifo #(
        .WIDTH (CMD_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .in_clk       (in_clk),
        .in_rst       (in_rst),
        .in_push      (fifo_push),
        .in_push_data ({bus.in_cmd_r_w, bus.in_cmd_addr, bus.in_cmd_wr_data}),
        .in_pop       (fifo_pop),
        .out_pop_data (fifo_rd_data),
        .out_full     (fifo_full),
        .out_empty    (fifo_empty),
        .out_level    (out_fifo_level)
    );

`ifdef TW_SEQ_TIMEOUT_EN
    localparam int unsigned TMO_BITS = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_BITS-1:0] tmo_cnt_q;

    // Reloaded on every entry to a handshake phase; expiry lands TIMEOUT_CYCLES after entry.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            tmo_cnt_q <= '0;
        end else if (state_d != state_q && (state_d == ISSUE || state_d == WAIT_DONE)) begin
            tmo_cnt_q <= TMO_BITS'(TIMEOUT_CYCLES);
        end else if (tmo_cnt_q != '0) begin
            tmo_cnt_q <= tmo_cnt_q - 1'b1;
        end
    end

    assign tmo_expired = (tmo_cnt_q <= TMO_BITS'(1));
`else
    assign tmo_expired = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        tw_r_w_d     = tw_r_w_q;
        tw_addr_d    = tw_addr_q;
        tw_wr_data_d = tw_wr_data_q;
        tw_start_d   = tw_start_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_addr_d   = rsp_addr_q;
        rsp_err_d    = rsp_err_q;
        fifo_pop     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop                               = 1'b1;
                    {tw_r_w_d, tw_addr_d, tw_wr_data_d}    = fifo_rd_data;
                    tw_start_d                             = 1'b1;
                    state_d                                = ISSUE;
                end
            end
            // The engine samples start only every few clocks, so hold it until busy shows.
            ISSUE: begin
                if (in_tw_busy) begin
                    tw_start_d = 1'b0;
                    state_d    = WAIT_DONE;
                end else if (tmo_expired) begin
                    tw_start_d  = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_addr_d  = tw_addr_q;
                    rsp_err_d   = 1'b1;
                    state_d     = RESPOND;
                end
            end
            WAIT_DONE: begin
                if (!in_tw_busy) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = (tw_r_w_q == TW_READ) ? in_tw_rd_data : '0;
                    rsp_addr_d  = tw_addr_q;
                    rsp_err_d   = 1'b0;
                    state_d     = RESPOND;
                end else if (tmo_expired) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_addr_d  = tw_addr_q;
                    rsp_err_d   = 1'b1;
                    state_d     = RESPOND;
                end
            end
            RESPOND: begin
                if (bus.in_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q      <= IDLE;
            tw_r_w_q     <= 1'b0;
            tw_addr_q    <= '0;
            tw_wr_data_q <= '0;
            tw_start_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_addr_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tw_r_w_q     <= tw_r_w_d;
            tw_addr_q    <= tw_addr_d;
            tw_wr_data_q <= tw_wr_data_d;
            tw_start_q   <= tw_start_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_addr_q   <= rsp_addr_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign out_tw_r_w        = tw_r_w_q;
    assign out_tw_addr       = tw_addr_q;
    assign out_tw_wr_data    = tw_wr_data_q;
    assign out_tw_start      = tw_start_q;
    assign bus.out_rsp_valid = rsp_valid_q;
    assign bus.out_rsp_data  = rsp_data_q;
    assign bus.out_rsp_addr  = rsp_addr_q;
    assign bus.out_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_tw_cmd_sequencer.sv
// Scoreboard bench for tw_cmd_sequencer with a behavioural three-wire engine model.
module tb_tw_cmd_sequencer;
    import tw_pkg::*;

    localparam int unsigned AB = 9;
    localparam int unsigned DB = 16;
`ifdef TW_SEQ_TIMEOUT_EN
    localparam int LONG_BUSY = 12;
`else
    localparam int LONG_BUSY = 80;
`endif

    typedef struct packed {
        logic [AB-1:0] addr;
        logic [DB-1:0] data;
        logic          err;
    } rsp_t;

    logic          in_clk = 1'b0;
    logic          in_rst;
    logic          out_tw_r_w;
    logic [AB-1:0] out_tw_addr;
    logic [DB-1:0] out_tw_wr_data;
    logic          out_tw_start;
    logic          in_tw_busy;
    logic [DB-1:0] in_tw_rd_data;
    logic [2:0]    out_fifo_level;

    int   n_checks = 0;
    int   n_fail   = 0;
    rsp_t exp_q[$];
    logic [DB-1:0] shadow  [1 << AB];
    logic [DB-1:0] eng_mem [1 << AB];
    logic eng_en;
    int   busy_len;

    always #5 in_clk = ~in_clk;

    tw_cmd_sequencer_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

    tw_cmd_sequencer #(
        .ADDR_BITS      (AB),
        .DATA_BITS      (DB),
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .in_clk         (in_clk),
        .in_rst         (in_rst),
        .bus            (bus),
        .out_tw_r_w     (out_tw_r_w),
        .out_tw_addr    (out_tw_addr),
        .out_tw_wr_data (out_tw_wr_data),
        .out_tw_start   (out_tw_start),
        .in_tw_busy     (in_tw_busy),
        .in_tw_rd_data  (in_tw_rd_data),
        .out_fifo_level (out_fifo_level)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_cmd(input logic rw, input logic [AB-1:0] a, input logic [DB-1:0] d,
                            input logic err);
        rsp_t e;
        int   n;
        bus.in_cmd_valid   = 1'b1;
        bus.in_cmd_r_w     = rw;
        bus.in_cmd_addr    = a;
        bus.in_cmd_wr_data = d;
        n = 0;
        while (!bus.out_cmd_ready && n < 500) begin
            @(posedge in_clk); #1;
            n++;
        end
        if (!bus.out_cmd_ready) begin
            check_eq("push_ready_timeout", bus.out_cmd_ready, 1);
            bus.in_cmd_valid = 1'b0;
            return;
        end
        e.addr = a;
        e.err  = err;
        e.data = (err || rw == TW_WRITE) ? '0 : shadow[a];
        if (rw == TW_WRITE && !err) shadow[a] = d;
        exp_q.push_back(e);
        @(posedge in_clk); #1;
        bus.in_cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc);
        int n = 0;
        while ((exp_q.size() != 0 || bus.out_rsp_valid) && n < max_cyc) begin
            @(posedge in_clk); #1;
            n++;
        end
        check_eq("drain_queue", exp_q.size(), 0);
        check_eq("drain_rsp_valid", bus.out_rsp_valid, 0);
    endtask

    // Engine model: busy rises some cycles after start is seen, reads come from eng_mem.
    initial begin : engine
        int            ph;
        int            cnt;
        logic          c_rw;
        logic [AB-1:0] c_addr;
        logic [DB-1:0] c_data;
        ph = 0;
        cnt = 0;
        in_tw_busy = 1'b0;
        in_tw_rd_data = '0;
        forever begin
            @(posedge in_clk); #1;
            if (in_rst) begin
                ph = 0;
                in_tw_busy = 1'b0;
            end else begin
                case (ph)
                    0: if (eng_en && out_tw_start) begin
                        c_rw = out_tw_r_w;
                        c_addr = out_tw_addr;
                        c_data = out_tw_wr_data;
                        cnt = 5;
                        ph = 1;
                    end
                    1: begin
                        cnt--;
                        if (cnt == 0) begin
                            in_tw_busy = 1'b1;
                            cnt = busy_len;
                            ph = 2;
                        end
                    end
                    default: begin
                        if (cnt == busy_len) check_eq("start_drop", out_tw_start, 0);
                        cnt--;
                        if (cnt == 0) begin
                            check_eq("tw_r_w_stable", out_tw_r_w, c_rw);
                            check_eq("tw_addr_stable", out_tw_addr, c_addr);
                            check_eq("tw_wr_data_stable", out_tw_wr_data, c_data);
                            if (c_rw == TW_WRITE) eng_mem[c_addr] = c_data;
                            else in_tw_rd_data = eng_mem[c_addr];
                            in_tw_busy = 1'b0;
                            ph = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Response monitor: handshake completes on the following rising edge.
    initial begin : monitor
        rsp_t e;
        forever begin
            @(negedge in_clk);
            if (!in_rst && bus.out_rsp_valid && bus.in_rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("rsp_unexpected", bus.out_rsp_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("rsp_addr", bus.out_rsp_addr, e.addr);
                    check_eq("rsp_data", bus.out_rsp_data, e.data);
                    check_eq("rsp_err", bus.out_rsp_err, e.err);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        for (int i = 0; i < (1 << AB); i++) begin
            shadow[i]  = 16'(i * 7 + 3);
            eng_mem[i] = shadow[i];
        end
        shadow[3]  = 16'h1234;
        eng_mem[3] = 16'h1234;

        in_rst = 1'b1;
        eng_en = 1'b1;
        busy_len = LONG_BUSY;
        bus.in_cmd_valid = 1'b0;
        bus.in_cmd_r_w = 1'b0;
        bus.in_cmd_addr = '0;
        bus.in_cmd_wr_data = '0;
        bus.in_rsp_ready = 1'b1;
        repeat (3) @(posedge in_clk);
        #1;
        check_eq("rst_cmd_ready", bus.out_cmd_ready, 1);
        check_eq("rst_fifo_level", out_fifo_level, 0);
        check_eq("rst_rsp_valid", bus.out_rsp_valid, 0);
        check_eq("rst_rsp_data", bus.out_rsp_data, 0);
        check_eq("rst_rsp_addr", bus.out_rsp_addr, 0);
        check_eq("rst_rsp_err", bus.out_rsp_err, 0);
        check_eq("rst_tw_start", out_tw_start, 0);
        check_eq("rst_tw_fields", {out_tw_r_w, out_tw_addr, out_tw_wr_data}, 0);
        in_rst = 1'b0;

        // Single write: two-cycle issue latency and exact command fields.
        push_cmd(TW_WRITE, 9'h1A5, 16'hBEEF, 1'b0);
        check_eq("issue_lat_early", out_tw_start, 0);
        @(posedge in_clk); #1;
        check_eq("issue_lat_start", out_tw_start, 1);
        check_eq("issue_r_w", out_tw_r_w, 1);
        check_eq("issue_addr", out_tw_addr, 9'h1A5);
        check_eq("issue_wr_data", out_tw_wr_data, 16'hBEEF);
        wait_drain(400);

        // Single read of a preloaded register.
        push_cmd(TW_READ, 9'h003, 16'h0000, 1'b0);
        wait_drain(400);

        // FIFO full: one command stuck in ISSUE, four queued.
        eng_en = 1'b0;
        busy_len = 8;
        push_cmd(TW_WRITE, 9'h010, 16'hA001, 1'b0);
        push_cmd(TW_WRITE, 9'h011, 16'hA002, 1'b0);
        push_cmd(TW_READ,  9'h010, 16'h0000, 1'b0);
        push_cmd(TW_WRITE, 9'h012, 16'hA003, 1'b0);
        push_cmd(TW_READ,  9'h005, 16'h0000, 1'b0);
        check_eq("full_level", out_fifo_level, 4);
        check_eq("full_ready", bus.out_cmd_ready, 0);
        eng_en = 1'b1;
        wait_drain(2000);
        check_eq("empty_level", out_fifo_level, 0);

        // Response backpressure: response holds, link stalls, next command stays queued.
        bus.in_rsp_ready = 1'b0;
        push_cmd(TW_READ,  9'h011, 16'h0000, 1'b0);
        push_cmd(TW_WRITE, 9'h020, 16'h5555, 1'b0);
        n = 0;
        while (!bus.out_rsp_valid && n < 400) begin
            @(posedge in_clk); #1;
            n++;
        end
        check_eq("bp_rsp_seen", bus.out_rsp_valid, 1);
        for (int i = 0; i < 20; i++) begin
            @(posedge in_clk); #1;
            check_eq("bp_rsp_valid", bus.out_rsp_valid, 1);
            check_eq("bp_rsp_addr", bus.out_rsp_addr, 9'h011);
            check_eq("bp_rsp_data", bus.out_rsp_data, exp_q[0].data);
            check_eq("bp_no_start", out_tw_start, 0);
            check_eq("bp_level", out_fifo_level, 1);
        end
        bus.in_rsp_ready = 1'b1;
        wait_drain(800);

`ifdef TW_SEQ_TIMEOUT_EN
        // Timeout: busy never rises, error response 16 cycles after ISSUE entry.
        eng_en = 1'b0;
        push_cmd(TW_READ, 9'h030, 16'h0000, 1'b1);
        for (int i = 0; i < 16; i++) begin
            @(posedge in_clk); #1;
            check_eq("tmo_not_yet", bus.out_rsp_valid, 0);
        end
        @(posedge in_clk); #1;
        check_eq("tmo_rsp_valid", bus.out_rsp_valid, 1);
        check_eq("tmo_rsp_err", bus.out_rsp_err, 1);
        check_eq("tmo_start_clr", out_tw_start, 0);
        eng_en = 1'b1;
        push_cmd(TW_WRITE, 9'h031, 16'h7777, 1'b0);
        wait_drain(400);
`endif

        // Reset while the engine is busy with two commands still queued.
        busy_len = LONG_BUSY;
        push_cmd(TW_READ, 9'h003, 16'h0000, 1'b0);
        push_cmd(TW_READ, 9'h010, 16'h0000, 1'b0);
        push_cmd(TW_READ, 9'h020, 16'h0000, 1'b0);
        n = 0;
        while (!in_tw_busy && n < 200) begin
            @(posedge in_clk); #1;
            n++;
        end
        check_eq("mid_busy_seen", in_tw_busy, 1);
        check_eq("mid_level", out_fifo_level, 2);
        #2;
        in_rst = 1'b1;
        #1;
        exp_q.delete();
        check_eq("mid_rst_level", out_fifo_level, 0);
        check_eq("mid_rst_ready", bus.out_cmd_ready, 1);
        check_eq("mid_rst_start", out_tw_start, 0);
        check_eq("mid_rst_tw_fields", {out_tw_r_w, out_tw_addr, out_tw_wr_data}, 0);
        check_eq("mid_rst_rsp", {bus.out_rsp_valid, bus.out_rsp_addr, bus.out_rsp_data}, 0);
        repeat (2) @(posedge in_clk);
        #1;
        in_rst = 1'b0;
        repeat (150) @(posedge in_clk);
        #1;
        check_eq("post_rst_rsp_valid", bus.out_rsp_valid, 0);
        check_eq("post_rst_start", out_tw_start, 0);
        check_eq("final_queue", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
